// File: rtl/washing_machine_ctrl_if.sv
// washing_machine_ctrl_if: user-panel bundle between the appliance top level and the sequencer.
//   start       - level request to begin a cycle
//   double_wash - run a second WASH/RINSE pair
//   dry_wash    - steam-clean-only cycle, taken when leaving IDLE
//   time_pause  - freeze the current timed phase while high
//   done        - registered cycle-complete flag from the sequencer
interface washing_machine_ctrl_if;
    logic start;
    logic double_wash;
    logic dry_wash;
    logic time_pause;
    logic done;
    modport master (output start, double_wash, dry_wash, time_pause, input done);
    modport slave  (input start, double_wash, dry_wash, time_pause, output done);
endinterface

// File: rtl/washing_machine_ctrl.sv
// washing_machine_ctrl: timed wash sequencer FILL_WATER -> WASH -> RINSE -> SPIN -> DRY, plus STEAM_CLEAN.
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - panel inputs (start, double_wash, dry_wash, time_pause) and done output
// One clock cycle stands for one second of machine time.
module washing_machine_ctrl #(
    parameter int FILL_CYCLES  = 10,
    parameter int WASH_CYCLES  = 50,
    parameter int RINSE_CYCLES = 50,
    parameter int SPIN_CYCLES  = 20,
    parameter int DRY_CYCLES   = 60,
    parameter int STEAM_CYCLES = 60,
    parameter int CNT_W        = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    washing_machine_ctrl_if.slave  bus
);
    localparam logic [2:0] IDLE        = 3'b000;
    localparam logic [2:0] FILL_WATER  = 3'b001;
    localparam logic [2:0] WASH        = 3'b010;
    localparam logic [2:0] RINSE       = 3'b011;
    localparam logic [2:0] SPIN        = 3'b100;
    localparam logic [2:0] DRY         = 3'b101;
    localparam logic [2:0] STEAM_CLEAN = 3'b110;
    logic [2:0]       current_state, next_state, after_state;
    logic [CNT_W-1:0] counter, last_count;
    logic             second_pass, timed, timeout, done_q;
    assign timed   = current_state != IDLE && current_state != 3'b111;
    assign timeout = timed && counter == last_count && !bus.time_pause;
    assign bus.done = done_q;
    always_comb begin
        last_count = current_state == FILL_WATER ? CNT_W'(FILL_CYCLES - 1)  :
                     current_state == WASH       ? CNT_W'(WASH_CYCLES - 1)  :
                     current_state == RINSE      ? CNT_W'(RINSE_CYCLES - 1) :
                     current_state == SPIN       ? CNT_W'(SPIN_CYCLES - 1)  :
                     current_state == DRY        ? CNT_W'(DRY_CYCLES - 1)   :
                                                   CNT_W'(STEAM_CYCLES - 1);
        // Only one extra WASH/RINSE pair: second_pass blocks a third
        after_state = current_state == FILL_WATER ? WASH :
                      current_state == WASH       ? RINSE :
                      current_state == RINSE      ? ((bus.double_wash && !second_pass) ? WASH : SPIN) :
                      current_state == SPIN       ? DRY : IDLE;
        next_state  = current_state == IDLE ? (bus.start ? (bus.dry_wash ? STEAM_CLEAN : FILL_WATER) : IDLE) :
                      !timed                ? IDLE :
                      timeout               ? after_state : current_state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current_state <= IDLE;
            counter       <= '0;
            second_pass   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            current_state <= next_state;
            // Counter is zero in IDLE and on every phase change, so each phase starts from 0
            counter       <= (!timed || timeout) ? '0 : bus.time_pause ? counter : counter + CNT_W'(1);
            if (timeout && current_state == RINSE)
                second_pass <= bus.double_wash && !second_pass;
            // done rises on the return to IDLE and survives only while IDLE persists
            done_q        <= next_state == IDLE &&
                             (current_state == DRY || current_state == STEAM_CLEAN ||
                              (current_state == IDLE && done_q));
        end
    end
endmodule

// File: tb/tb_washing_machine_ctrl.sv
// tb_washing_machine_ctrl: directed test-plan steps plus randomized panel activity against a phase-timer model.
`timescale 1ns/1ps
module tb_washing_machine_ctrl;
    localparam logic [2:0] S_IDLE = 3'd0, S_FILL = 3'd1, S_WASH = 3'd2, S_RINSE = 3'd3;
    localparam logic [2:0] S_SPIN = 3'd4, S_DRY = 3'd5, S_STEAM = 3'd6;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail = 0;
    int   dur [8] = '{0, 10, 50, 50, 20, 60, 60, 0};
    logic [2:0] m_st;
    int   m_cnt;
    bit   m_pass, m_done;
    washing_machine_ctrl_if bus ();
    washing_machine_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #500 clk = ~clk;
    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        m_st = S_IDLE; m_cnt = 0; m_pass = 0; m_done = 0;
    endtask
    // Phase model: each phase lasts dur[] unpaused seconds, then hands over to its successor
    task automatic model_edge();
        if (m_st == S_IDLE) begin
            if (bus.start) begin
                m_st = bus.dry_wash ? S_STEAM : S_FILL;
                m_done = 0;
            end
        end else if (!bus.time_pause) begin
            m_cnt++;
            if (m_cnt == dur[m_st]) begin
                m_cnt = 0;
                case (m_st)
                    S_FILL:  m_st = S_WASH;
                    S_WASH:  m_st = S_RINSE;
                    S_RINSE: if (bus.double_wash && !m_pass) begin m_pass = 1; m_st = S_WASH; end
                             else begin m_pass = 0; m_st = S_SPIN; end
                    S_SPIN:  m_st = S_DRY;
                    default: begin m_st = S_IDLE; m_done = 1; end
                endcase
            end
        end
    endtask
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            chk("timeout", 32'(dut.timeout),
                32'(rst_n && m_st != S_IDLE && m_cnt == dur[m_st] - 1 && !bus.time_pause));
            @(posedge clk);
            if (rst_n) model_edge();
            #1;
            chk("model_state", 32'(dut.current_state), 32'(m_st));
            chk("model_counter", 32'(dut.counter), 32'(m_cnt));
            chk("model_done", 32'(bus.done), 32'(m_done));
        end
    endtask
    initial begin
        rst_n = 1'b0;
        bus.start = 1'b1; bus.double_wash = 1'b0; bus.dry_wash = 1'b0; bus.time_pause = 1'b0;
        model_reset();
        #1200;
        chk("reset_state", 32'(dut.current_state), 32'(S_IDLE));
        chk("reset_done", 32'(bus.done), 0);
        chk("reset_counter", 32'(dut.counter), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1);  chk("fill_entry", 32'(dut.current_state), 32'(S_FILL));
        step(10); chk("wash_entry", 32'(dut.current_state), 32'(S_WASH));
        step(50); chk("rinse_entry", 32'(dut.current_state), 32'(S_RINSE));
        step(50); chk("spin_entry", 32'(dut.current_state), 32'(S_SPIN));
        step(20); chk("dry_entry", 32'(dut.current_state), 32'(S_DRY));
        step(59);
        bus.start = 1'b0;
        step(1);  chk("idle_after_dry", 32'(dut.current_state), 32'(S_IDLE));
        chk("done_set", 32'(bus.done), 1);
        step(6);  chk("done_held", 32'(bus.done), 1);
        chk("idle_held", 32'(dut.current_state), 32'(S_IDLE));
        bus.start = 1'b1;
        step(1);  chk("done_cleared", 32'(bus.done), 0);
        chk("restart_fill", 32'(dut.current_state), 32'(S_FILL));
        bus.double_wash = 1'b1;
        step(10); chk("dw_wash1", 32'(dut.current_state), 32'(S_WASH));
        step(50); chk("dw_rinse1", 32'(dut.current_state), 32'(S_RINSE));
        step(50); chk("dw_wash2", 32'(dut.current_state), 32'(S_WASH));
        step(50); chk("dw_rinse2", 32'(dut.current_state), 32'(S_RINSE));
        step(50); chk("dw_spin_no_third", 32'(dut.current_state), 32'(S_SPIN));
        bus.time_pause = 1'b1;
        step(10); chk("spin_paused", 32'(dut.current_state), 32'(S_SPIN));
        chk("spin_paused_cnt", 32'(dut.counter), 0);
        bus.time_pause = 1'b0;
        step(19); chk("spin_before_end", 32'(dut.current_state), 32'(S_SPIN));
        step(1);  chk("dry_after_pause", 32'(dut.current_state), 32'(S_DRY));
        bus.double_wash = 1'b0;
        step(60); chk("idle_pulse_done", 32'(bus.done), 1);
        chk("idle_pulse_state", 32'(dut.current_state), 32'(S_IDLE));
        step(1);  chk("pulse_end_done", 32'(bus.done), 0);
        chk("auto_restart", 32'(dut.current_state), 32'(S_FILL));
        step(5);
        bus.time_pause = 1'b1;
        step(3);  chk("fill_paused", 32'(dut.current_state), 32'(S_FILL));
        chk("fill_paused_cnt", 32'(dut.counter), 5);
        bus.time_pause = 1'b0;
        step(4);  chk("fill_resume", 32'(dut.current_state), 32'(S_FILL));
        step(1);  chk("wash_after_resume", 32'(dut.current_state), 32'(S_WASH));
        rst_n = 1'b0;
        #10;
        chk("midrun_reset_state", 32'(dut.current_state), 32'(S_IDLE));
        chk("midrun_reset_cnt", 32'(dut.counter), 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.dry_wash = 1'b1;
        bus.start = 1'b1;
        step(1);  chk("steam_entry", 32'(dut.current_state), 32'(S_STEAM));
        bus.dry_wash = 1'b0;
        bus.start = 1'b0;
        step(59); chk("steam_hold", 32'(dut.current_state), 32'(S_STEAM));
        step(1);  chk("steam_idle", 32'(dut.current_state), 32'(S_IDLE));
        chk("steam_done", 32'(bus.done), 1);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.dry_wash = 1'($urandom_range(0, 1));
                #($urandom_range(5, 300));
                rst_n = 1'b0;
                #1;
                chk("rand_reset_state", 32'(dut.current_state), 32'(S_IDLE));
                chk("rand_reset_cnt", 32'(dut.counter), 0);
                chk("rand_reset_done", 32'(bus.done), 0);
                model_reset();
                step(1);
                rst_n = 1'b1;
            end else begin
                bus.start = $urandom_range(0, 3) != 0;
                bus.dry_wash = $urandom_range(0, 3) == 0;
                bus.double_wash = 1'($urandom_range(0, 1));
                bus.time_pause = $urandom_range(0, 3) == 0;
                step(1);
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
